// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its prefetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    // Default address / instruction width of the fetch path.
    localparam int DEFAULT_XLEN = 32;

    // Every instruction is one aligned 32-bit word.
    localparam int INSTR_BYTES = 4;

    // One prefetch buffer entry: the fetched word and the address it came from.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with a combinational head read.
// Latency: a push is visible at the head one cycle later; a pop frees its slot at once.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 empty the buffer; overrides push and pop
//   push_vld, push_dat    write one entry at the tail
//   pop_vld               remove the head entry (ignored while empty)
//   head_dat              current head entry, valid while !empty
//   full, empty, count    occupancy status
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_vld,
    input  entry_t                 push_dat,
    input  logic                   pop_vld,
    output entry_t                 head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    // A full buffer may still accept a write when its head leaves this cycle.
    assign do_pop  = pop_vld && !empty && !flush;
    assign do_push = push_vld && (!full || do_pop) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, buffers responses, handles redirects.
// Latency: request accepted in cycle N -> response N+1 at the earliest -> instr_valid in N+2.
// Backpressure: requests stop while buffered + outstanding reaches DEPTH; decode stalls via instr_ready.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   redirect_valid, redirect_pc    flush everything and restart fetch at redirect_pc (word aligned)
//   imem_req_valid/ready/addr      fetch request channel to instruction memory
//   imem_rsp_valid/data            in-order responses, one per accepted request
//   instr_valid/ready/data/pc      buffered instruction stream towards decode
//   fetch_count, drop_total        performance counters, only with FETCH_PERF_EN defined
//
// Build option: define FETCH_PERF_EN to add the fetch_count / drop_total counters and ports.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN     = DEFAULT_XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [15:0]     drop_total
`endif
);

    localparam int              CNT_W            = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK       = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;
    localparam logic [CNT_W:0]  CREDIT_LIMIT     = (CNT_W + 1)'(DEPTH);

    // Same layout as fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    // Address of the next response that will be kept. Requests after a redirect are
    // strictly sequential and stale responses are dropped, so this needs no per-request queue.
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    entry_t           fifo_head;
    entry_t           fifo_push_dat;
    logic             credit_ok;
    logic             req_fire;
    logic             rsp_drop;
    logic             rsp_keep;
    logic             instr_pop;

    assign redirect_target = redirect_pc & ALIGN_MASK;

    // Every buffered entry and every request still in flight holds one buffer slot,
    // so a response can always be written when it arrives.
    assign credit_ok = !fifo_full &&
                       (({1'b0, fifo_count} + {1'b0, outstanding_q}) < CREDIT_LIMIT);

    // Gated by rst so the request is low while reset is held and rises in the first cycle after.
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q & ALIGN_MASK;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response arriving during a redirect belongs to the old stream as well.
    assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_count_q != '0));
    assign rsp_keep = imem_rsp_valid && !rsp_drop;

    assign instr_valid = !fifo_empty;
    assign instr_data  = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign instr_pop   = instr_valid && instr_ready && !redirect_valid;

    assign fifo_push_dat = '{pc: rsp_pc_q, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fetch_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_vld (rsp_keep),
        .push_dat (fifo_push_dat),
        .pop_vld  (instr_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_count_d  = drop_count_q;

        // Outstanding counts every response, kept or dropped.
        if (req_fire && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (imem_rsp_valid && !req_fire) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            // Everything still in flight is stale; the response landing now is dropped directly.
            drop_count_d = (imem_rsp_valid && (outstanding_q != '0)) ?
                           (outstanding_q - CNT_W'(1)) : outstanding_q;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
            end
            if (rsp_drop) begin
                drop_count_d = drop_count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC_ALIGNED;
            rsp_pc_q      <= RESET_PC_ALIGNED;
            outstanding_q <= '0;
            drop_count_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [15:0] drop_total_q, drop_total_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        drop_total_d  = drop_total_q;
        if (instr_pop) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (rsp_drop && (drop_total_q != 16'hFFFF)) begin
            drop_total_d = drop_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            drop_total_q  <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            drop_total_q  <= drop_total_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign drop_total  = drop_total_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [15:0] drop_total;
`endif

    int checks = 0;
    int failures = 0;

    // Memory model state and observation logs.
    logic        mem_hold = 1'b0;
    logic [31:0] mem_q [$];
    logic [31:0] req_log [$];
    logic [31:0] got_pc [$];
    logic [31:0] got_dat [$];
    logic        acc_s = 1'b0;
    logic [31:0] acc_addr_s = 32'h0;
    logic        rsp_s = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .drop_total     (drop_total)
`endif
    );

    // Sample handshakes mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        acc_s      <= imem_req_valid && imem_req_ready && !rst;
        acc_addr_s <= imem_req_addr;
        rsp_s      <= imem_rsp_valid;
        if (imem_req_valid && imem_req_ready && !rst) req_log.push_back(imem_req_addr);
        if (!rst && instr_valid && instr_ready && !redirect_valid) begin
            got_pc.push_back(instr_pc);
            got_dat.push_back(instr_data);
        end
    end

    // In-order memory: answers the oldest pending request one cycle after acceptance
    // at the earliest; data is the bitwise inverse of the address.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mem_q.delete();
            imem_rsp_valid <= 1'b0;
        end else begin
            if (rsp_s && mem_q.size() > 0) void'(mem_q.pop_front());
            if (acc_s) mem_q.push_back(acc_addr_s);
            if (!mem_hold && mem_q.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= ~mem_q[0];
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset over two edges and returns in cycle 0 with rst just released.
    task automatic apply_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        req_log.delete();
        got_pc.delete();
        got_dat.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_req: got vld=%b addr=%h expected vld=1 addr=00000000", imem_req_valid, imem_req_addr);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] e;
        apply_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b1; mem_hold = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            e = 32'(c * 4);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin
                failures++;
                $display("FAIL stream_req c=%0d: got vld=%b addr=%h expected vld=1 addr=%h", c, imem_req_valid, imem_req_addr, e);
            end
            checks++;
            if (instr_valid !== (c >= 2)) begin
                failures++; $display("FAIL stream_instr_valid c=%0d: got %b expected %b", c, instr_valid, (c >= 2));
            end
            if (c >= 2) begin
                e = 32'((c - 2) * 4);
                checks++;
                if (instr_pc !== e || instr_data !== ~e) begin
                    failures++;
                    $display("FAIL stream_instr c=%0d: got pc=%h data=%h expected pc=%h data=%h", c, instr_pc, instr_data, e, ~e);
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        apply_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b0; mem_hold = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        checks++;
        if (req_log.size() != 4) begin
            failures++; $display("FAIL full_req_count: got %0d expected 4", req_log.size());
        end
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL full_state: got req_vld=%b instr_vld=%b pc=%h expected 0 1 00000000", imem_req_valid, instr_valid, instr_pc);
        end
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        checks++;
        if (req_log.size() != 5 || req_log[req_log.size()-1] !== 32'h10) begin
            failures++; $display("FAIL full_one_refill: got count=%0d expected count=5 last=00000010", req_log.size());
        end
        checks++;
        if (imem_req_valid !== 1'b0 || instr_pc !== 32'h4 || got_pc.size() != 1) begin
            failures++;
            $display("FAIL full_after_pop: got req_vld=%b pc=%h pops=%0d expected 0 00000004 1", imem_req_valid, instr_pc, got_pc.size());
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b1; mem_hold = 1'b1;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || req_log.size() != 3) begin
            failures++;
            $display("FAIL redir_hold: got vld=%b reqs=%0d expected vld=0 reqs=3", imem_req_valid, req_log.size());
        end
        tick();
        redirect_valid = 1'b0; mem_hold = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_first_req: got vld=%b addr=%h ivld=%b expected 1 00000100 0", imem_req_valid, imem_req_addr, instr_valid);
        end
        repeat (8) tick();
        @(negedge clk);
        checks++;
        if (got_pc.size() < 2) begin
            failures++; $display("FAIL redir_delivered: got %0d instrs expected at least 2", got_pc.size());
        end else if (got_pc[0] !== 32'h100 || got_pc[1] !== 32'h104 || got_dat[0] !== ~32'h100) begin
            failures++;
            $display("FAIL redir_delivered: got pc0=%h pc1=%h d0=%h expected 00000100 00000104 fffffeff", got_pc[0], got_pc[1], got_dat[0]);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        imem_req_ready = 1'b0; instr_ready = 1'b1; mem_hold = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_top: got vld=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_zero: got vld=%b addr=%h expected 1 00000000", imem_req_valid, imem_req_addr);
        end
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (got_pc.size() < 2) begin
            failures++; $display("FAIL wrap_delivered: got %0d instrs expected at least 2", got_pc.size());
        end else if (got_pc[0] !== 32'hFFFF_FFFC || got_pc[1] !== 32'h0) begin
            failures++; $display("FAIL wrap_delivered: got pc0=%h pc1=%h expected fffffffc 00000000", got_pc[0], got_pc[1]);
        end
    endtask

    task automatic test_back_to_back();
        int n200;
        apply_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b1; mem_hold = 1'b1;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200; mem_hold = 1'b0;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first_req: got vld=%b addr=%h ivld=%b expected 1 00000300 0", imem_req_valid, imem_req_addr, instr_valid);
        end
        repeat (6) tick();
        @(negedge clk);
        n200 = 0;
        foreach (got_pc[i]) if (got_pc[i][31:8] == 24'h2) n200++;
        checks++;
        if (got_pc.size() < 1 || n200 != 0) begin
            failures++; $display("FAIL b2b_delivered: got %0d instrs, %0d from 0x200 stream expected >=1 and 0", got_pc.size(), n200);
        end else if (got_pc[0] !== 32'h300) begin
            failures++; $display("FAIL b2b_first_pc: got %h expected 00000300", got_pc[0]);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b1; mem_hold = 1'b0;
        tick(); tick(); tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin
                failures++;
                $display("FAIL stall_hold i=%0d: got vld=%b addr=%h expected 1 0000000c", i, imem_req_valid, imem_req_addr);
            end
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (imem_req_addr !== 32'h10 || req_log.size() != 4) begin
            failures++; $display("FAIL stall_release: got addr=%h reqs=%0d expected 00000010 4", imem_req_addr, req_log.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        imem_req_ready = 1'b1; instr_ready = 1'b1; mem_hold = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs: got req_vld=%b instr_vld=%b expected 0 0", imem_req_valid, instr_valid);
        end
        tick();
        got_pc.delete(); got_dat.delete(); req_log.delete();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_restart: got vld=%b addr=%h ivld=%b expected 1 00000000 0", imem_req_valid, imem_req_addr, instr_valid);
        end
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (got_pc.size() < 2) begin
            failures++; $display("FAIL midreset_stream: got %0d instrs expected at least 2", got_pc.size());
        end else if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4) begin
            failures++; $display("FAIL midreset_stream: got pc0=%h pc1=%h expected 00000000 00000004", got_pc[0], got_pc[1]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

endmodule
